devil_snoop_responder: RTL and testbench

- Parametrised, programmable ACE snoop responder for the devil fabric: accepts AC-channel snoops and returns CR-channel responses.
- Matched snoops get a programmable response delay and a forced CRRESP; unmatched snoops are answered immediately with a default CRRESP.
- Generalises single-window, fixed-width delay logic to NUM_WIN address windows, a parametrised delay and counter width, and one-shot/continuous arming with a match counter.
- Sits between the snoop port of the interconnect and the AXI-Lite control register file, which drives all cfg_* inputs and reads all sts_* outputs.

---
 rtl/devil_snoop_pkg.sv | 29 ++
 rtl/devil_addr_win_match.sv | 45 ++++
 rtl/devil_snoop_responder.sv | 209 ++++++++++++++++++++
 tb/tb_devil_snoop_responder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/devil_snoop_pkg.sv
// -----------------------------------------------------------------------------
// devil_snoop_pkg
// Shared types and constants for the devil fabric ACE snoop responder.
//   - snoop_state_e : responder FSM states
//   - CR_*          : CRRESP bit positions
//   - AC_*          : ACSNOOP encodings used when programming the type filter
// Optional feature macro used by the top level: DEVIL_SNOOP_TRACE_EN.
// -----------------------------------------------------------------------------
package devil_snoop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RESP  = 2'd2
    } snoop_state_e;

    // CRRESP bit positions
    localparam int CR_DATA_TRANSFER = 0;
    localparam int CR_ERROR         = 1;
    localparam int CR_PASS_DATA     = 2;
    localparam int CR_IS_SHARED     = 3;
    localparam int CR_WAS_UNIQUE    = 4;

    // ACSNOOP encodings
    localparam logic [3:0] AC_READ_ONCE     = 4'b0000;
    localparam logic [3:0] AC_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] AC_MAKE_INVALID  = 4'b1101;

endpackage : devil_snoop_pkg

// File: rtl/devil_addr_win_match.sv
// -----------------------------------------------------------------------------
// devil_addr_win_match
// Purely combinational NUM_WIN-way address window compare.
// Window i hits when win_en[i] and base_i <= addr < base_i + size_i.
// Ports:
//   addr     in  ADDR_W          address under test
//   win_en   in  NUM_WIN         per-window enable
//   win_base in  NUM_WIN*ADDR_W  bases, window 0 in the LSBs
//   win_size in  NUM_WIN*SIZE_W  sizes in bytes
//   hit      out 1               any enabled window contains addr
// -----------------------------------------------------------------------------
module devil_addr_win_match
    import devil_snoop_pkg::*;
#(
    parameter int ADDR_W  = 44,
    parameter int NUM_WIN = 4,
    parameter int SIZE_W  = 32
) (
    input  logic [ADDR_W-1:0]         addr,
    input  logic [NUM_WIN-1:0]        win_en,
    input  logic [NUM_WIN*ADDR_W-1:0] win_base,
    input  logic [NUM_WIN*SIZE_W-1:0] win_size,
    output logic                      hit
);

    logic [NUM_WIN-1:0] win_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WIN; gi++) begin : g_win
            logic [ADDR_W:0] base_ext;
            logic [ADDR_W:0] end_ext;
            // One extra bit so base+size never wraps; size 0 gives end==base,
            // which makes the half-open range empty.
            assign base_ext    = {1'b0, win_base[gi*ADDR_W +: ADDR_W]};
            assign end_ext     = base_ext + (ADDR_W+1)'(win_size[gi*SIZE_W +: SIZE_W]);
            assign win_hit[gi] = win_en[gi]
                               & ({1'b0, addr} >= base_ext)
                               & ({1'b0, addr} <  end_ext);
        end
    endgenerate

    assign hit = |win_hit;

endmodule : devil_addr_win_match

// File: rtl/devil_snoop_responder.sv
// -----------------------------------------------------------------------------
// devil_snoop_responder
// Programmable ACE snoop responder. Accepts one AC snoop at a time and answers
// on CR. Snoops that match the type/address filters while armed are answered
// with cfg_crresp after cfg_delay cycles; all others get cfg_dflt_crresp at once.
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   acvalid/acready/acaddr/acsnoop  AC snoop address channel
//   crvalid/crready/crresp        CR snoop response channel
//   cfg_*                         control register inputs
//   sts_clr                       pulse: clears sts_done and sts_match_cnt
//   sts_done/sts_busy/sts_match_cnt status outputs
//   trc_acaddr/trc_acsnoop        (DEVIL_SNOOP_TRACE_EN only) last matched snoop
// Optional feature macro: DEVIL_SNOOP_TRACE_EN.
// -----------------------------------------------------------------------------
module devil_snoop_responder
    import devil_snoop_pkg::*;
#(
    parameter int ADDR_W  = 44,
    parameter int NUM_WIN = 4,
    parameter int SIZE_W  = 32,
    parameter int DELAY_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      acvalid,
    output logic                      acready,
    input  logic [ADDR_W-1:0]         acaddr,
    input  logic [3:0]                acsnoop,
    output logic                      crvalid,
    input  logic                      crready,
    output logic [4:0]                crresp,
    input  logic                      cfg_en,
    input  logic                      cfg_oneshot,
    input  logic                      cfg_acflt_en,
    input  logic [3:0]                cfg_acsnoop,
    input  logic                      cfg_addrflt_en,
    input  logic [NUM_WIN-1:0]        cfg_win_en,
    input  logic [NUM_WIN*ADDR_W-1:0] cfg_win_base,
    input  logic [NUM_WIN*SIZE_W-1:0] cfg_win_size,
    input  logic [DELAY_W-1:0]        cfg_delay,
    input  logic [4:0]                cfg_crresp,
    input  logic [4:0]                cfg_dflt_crresp,
    input  logic                      sts_clr,
    output logic                      sts_done,
    output logic                      sts_busy,
    output logic [CNT_W-1:0]          sts_match_cnt
`ifdef DEVIL_SNOOP_TRACE_EN
    ,
    output logic [ADDR_W-1:0]         trc_acaddr,
    output logic [3:0]                trc_acsnoop
`endif
);

    snoop_state_e       state_reg;
    logic               acready_reg;
    logic               crvalid_reg;
    logic [4:0]         crresp_reg;
    logic [DELAY_W-1:0] delay_cnt_reg;
    logic               matched_reg;     // this snoop matched while armed
    logic               oneshot_reg;
    logic [4:0]         resp_fwd_reg;
    logic [4:0]         resp_dflt_reg;
    logic               done_reg, done_next;
    logic [CNT_W-1:0]   match_cnt_reg, match_cnt_next, match_cnt_base;

    logic win_hit;
    logic snoop_match;
    logic armed;
    logic ac_hs;
    logic match_done;

    devil_addr_win_match #(
        .ADDR_W  (ADDR_W),
        .NUM_WIN (NUM_WIN),
        .SIZE_W  (SIZE_W)
    ) u_win_match (
        .addr     (acaddr),
        .win_en   (cfg_win_en),
        .win_base (cfg_win_base),
        .win_size (cfg_win_size),
        .hit      (win_hit)
    );

    assign snoop_match = (~cfg_acflt_en | (acsnoop == cfg_acsnoop))
                       & (~cfg_addrflt_en | win_hit);
    assign armed       = cfg_en & ~(cfg_oneshot & done_reg);
    assign ac_hs       = acvalid & acready_reg;
    // crvalid is only ever high in RESP, so this is a matched completion.
    assign match_done  = crvalid_reg & crready & matched_reg;

    // A clear in the same cycle as a completion is applied first so the
    // completion is still recorded.
    always_comb begin
        match_cnt_base = sts_clr ? '0 : match_cnt_reg;
        match_cnt_next = match_cnt_base;
        if (match_done && !(&match_cnt_base)) begin
            match_cnt_next = match_cnt_base + CNT_W'(1);
        end
        done_next = (done_reg & ~sts_clr) | (match_done & oneshot_reg);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= ST_IDLE;
            acready_reg   <= 1'b0;
            crvalid_reg   <= 1'b0;
            crresp_reg    <= '0;
            delay_cnt_reg <= '0;
            matched_reg   <= 1'b0;
            oneshot_reg   <= 1'b0;
            resp_fwd_reg  <= '0;
            resp_dflt_reg <= '0;
            done_reg      <= 1'b0;
            match_cnt_reg <= '0;
        end else begin
            done_reg      <= done_next;
            match_cnt_reg <= match_cnt_next;
            case (state_reg)
                ST_IDLE: begin
                    acready_reg <= 1'b1;
                    if (ac_hs) begin
                        acready_reg   <= 1'b0;
                        matched_reg   <= snoop_match & armed;
                        oneshot_reg   <= cfg_oneshot;
                        resp_fwd_reg  <= cfg_crresp;
                        resp_dflt_reg <= cfg_dflt_crresp;
                        delay_cnt_reg <= cfg_delay;
                        if (snoop_match && armed && (cfg_delay != '0)) begin
                            state_reg <= ST_DELAY;
                        end else begin
                            state_reg   <= ST_RESP;
                            crvalid_reg <= 1'b1;
                            crresp_reg  <= (snoop_match & armed) ? cfg_crresp
                                                                 : cfg_dflt_crresp;
                        end
                    end
                end
                ST_DELAY: begin
                    delay_cnt_reg <= delay_cnt_reg - DELAY_W'(1);
                    if (!cfg_en) begin
                        // Disabled mid-wait: answer now with the default and
                        // do not count it as a match.
                        matched_reg <= 1'b0;
                        state_reg   <= ST_RESP;
                        crvalid_reg <= 1'b1;
                        crresp_reg  <= resp_dflt_reg;
                    end else if (delay_cnt_reg == DELAY_W'(1)) begin
                        state_reg   <= ST_RESP;
                        crvalid_reg <= 1'b1;
                        crresp_reg  <= resp_fwd_reg;
                    end
                end
                ST_RESP: begin
                    if (crready) begin
                        state_reg   <= ST_IDLE;
                        crvalid_reg <= 1'b0;
                        acready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    crvalid_reg <= 1'b0;
                    acready_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEVIL_SNOOP_TRACE_EN
    logic [ADDR_W-1:0] trc_addr_lat_reg;
    logic [3:0]        trc_snoop_lat_reg;
    logic [ADDR_W-1:0] trc_acaddr_reg;
    logic [3:0]        trc_acsnoop_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            trc_addr_lat_reg  <= '0;
            trc_snoop_lat_reg <= '0;
            trc_acaddr_reg    <= '0;
            trc_acsnoop_reg   <= '0;
        end else begin
            if (ac_hs) begin
                trc_addr_lat_reg  <= acaddr;
                trc_snoop_lat_reg <= acsnoop;
            end
            if (match_done) begin
                trc_acaddr_reg  <= trc_addr_lat_reg;
                trc_acsnoop_reg <= trc_snoop_lat_reg;
            end else if (sts_clr) begin
                trc_acaddr_reg  <= '0;
                trc_acsnoop_reg <= '0;
            end
        end
    end

    assign trc_acaddr  = trc_acaddr_reg;
    assign trc_acsnoop = trc_acsnoop_reg;
`endif

    assign acready       = acready_reg;
    assign crvalid       = crvalid_reg;
    assign crresp        = crresp_reg;
    assign sts_done      = done_reg;
    assign sts_busy      = (state_reg != ST_IDLE);
    assign sts_match_cnt = match_cnt_reg;

endmodule : devil_snoop_responder

// File: tb/tb_devil_snoop_responder.sv
// -----------------------------------------------------------------------------
// tb_devil_snoop_responder
// Directed self-checking bench for devil_snoop_responder. Inputs change and
// outputs are sampled on the falling edge of tb_clk.
// -----------------------------------------------------------------------------
module tb_devil_snoop_responder;
    import devil_snoop_pkg::*;

    localparam int ADDR_W  = 44;
    localparam int NUM_WIN = 4;
    localparam int SIZE_W  = 32;
    localparam int DELAY_W = 16;
    localparam int CNT_W   = 32;

    localparam logic [4:0] RESP_FWD  = 5'h0B;
    localparam logic [4:0] RESP_DFLT = 5'h10;

    logic                      tb_clk = 1'b0;
    logic                      aresetn;
    logic                      acvalid;
    logic                      acready;
    logic [ADDR_W-1:0]         acaddr;
    logic [3:0]                acsnoop;
    logic                      crvalid;
    logic                      crready;
    logic [4:0]                crresp;
    logic                      cfg_en;
    logic                      cfg_oneshot;
    logic                      cfg_acflt_en;
    logic [3:0]                cfg_acsnoop;
    logic                      cfg_addrflt_en;
    logic [NUM_WIN-1:0]        cfg_win_en;
    logic [NUM_WIN*ADDR_W-1:0] cfg_win_base;
    logic [NUM_WIN*SIZE_W-1:0] cfg_win_size;
    logic [DELAY_W-1:0]        cfg_delay;
    logic [4:0]                cfg_crresp;
    logic [4:0]                cfg_dflt_crresp;
    logic                      sts_clr;
    logic                      sts_done;
    logic                      sts_busy;
    logic [CNT_W-1:0]          sts_match_cnt;
`ifdef DEVIL_SNOOP_TRACE_EN
    logic [ADDR_W-1:0]         trc_acaddr;
    logic [3:0]                trc_acsnoop;
`endif

    int checks = 0;
    int errors = 0;

    always #5 tb_clk = ~tb_clk;

    devil_snoop_responder #(
        .ADDR_W  (ADDR_W),
        .NUM_WIN (NUM_WIN),
        .SIZE_W  (SIZE_W),
        .DELAY_W (DELAY_W),
        .CNT_W   (CNT_W)
    ) dut (
        .aclk            (tb_clk),
        .aresetn         (aresetn),
        .acvalid         (acvalid),
        .acready         (acready),
        .acaddr          (acaddr),
        .acsnoop         (acsnoop),
        .crvalid         (crvalid),
        .crready         (crready),
        .crresp          (crresp),
        .cfg_en          (cfg_en),
        .cfg_oneshot     (cfg_oneshot),
        .cfg_acflt_en    (cfg_acflt_en),
        .cfg_acsnoop     (cfg_acsnoop),
        .cfg_addrflt_en  (cfg_addrflt_en),
        .cfg_win_en      (cfg_win_en),
        .cfg_win_base    (cfg_win_base),
        .cfg_win_size    (cfg_win_size),
        .cfg_delay       (cfg_delay),
        .cfg_crresp      (cfg_crresp),
        .cfg_dflt_crresp (cfg_dflt_crresp),
        .sts_clr         (sts_clr),
        .sts_done        (sts_done),
        .sts_busy        (sts_busy),
        .sts_match_cnt   (sts_match_cnt)
`ifdef DEVIL_SNOOP_TRACE_EN
        ,
        .trc_acaddr      (trc_acaddr),
        .trc_acsnoop     (trc_acsnoop)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clr();
        sts_clr = 1'b1;
        @(negedge tb_clk);
        sts_clr = 1'b0;
    endtask

    // One snoop with crready held high. Returns the cycle distance from the
    // handshake cycle to the first crvalid cycle, the response seen there and
    // whether acready was ever high while the snoop was outstanding.
    task automatic do_snoop(input logic [ADDR_W-1:0] addr, input logic [3:0] snp,
                            input bit clr_at_resp, output int lat,
                            output logic [4:0] resp, output bit ac_seen);
        int n;
        n = 0;
        while (acready !== 1'b1 && n < 50) begin
            @(negedge tb_clk);
            n++;
        end
        chk("acready_wait", {63'd0, acready}, 64'd1);
        acaddr  = addr;
        acsnoop = snp;
        acvalid = 1'b1;
        @(negedge tb_clk);
        acvalid = 1'b0;
        lat     = 1;
        ac_seen = 1'b0;
        while (crvalid !== 1'b1 && lat < 300) begin
            if (acready) ac_seen = 1'b1;
            @(negedge tb_clk);
            lat++;
        end
        if (acready) ac_seen = 1'b1;
        resp = crresp;
        if (clr_at_resp) sts_clr = 1'b1;
        $display("snoop addr=%h type=%h latency=%0d crresp=%h", addr, snp, lat, resp);
        @(negedge tb_clk);
        sts_clr = 1'b0;
    endtask

    initial begin
        int         lat;
        logic [4:0] resp;
        bit         ac_seen;

        aresetn         = 1'b0;
        acvalid         = 1'b0;
        acaddr          = '0;
        acsnoop         = '0;
        crready         = 1'b1;
        cfg_en          = 1'b0;
        cfg_oneshot     = 1'b0;
        cfg_acflt_en    = 1'b0;
        cfg_acsnoop     = '0;
        cfg_addrflt_en  = 1'b0;
        cfg_win_en      = '0;
        cfg_win_base    = '0;
        cfg_win_size    = '0;
        cfg_delay       = '0;
        cfg_crresp      = '0;
        cfg_dflt_crresp = '0;
        sts_clr         = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge tb_clk);
        chk("rst_acready", {63'd0, acready}, 64'd0);
        chk("rst_crvalid", {63'd0, crvalid}, 64'd0);
        chk("rst_crresp", {59'd0, crresp}, 64'd0);
        chk("rst_done", {63'd0, sts_done}, 64'd0);
        chk("rst_busy", {63'd0, sts_busy}, 64'd0);
        chk("rst_cnt", {32'd0, sts_match_cnt}, 64'd0);
        aresetn = 1'b1;
        chk("rel_acready0", {63'd0, acready}, 64'd0);
        @(negedge tb_clk);
        chk("rel_acready1", {63'd0, acready}, 64'd1);

        // ---------------- filters off, no delay ----------------
        cfg_en          = 1'b1;
        cfg_crresp      = 5'h01;
        cfg_dflt_crresp = 5'h00;
        do_snoop(44'h40, AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
        chk("t1_lat", 64'(lat), 64'd1);
        chk("t1_resp", {59'd0, resp}, 64'h01);
        chk("t1_cnt", {32'd0, sts_match_cnt}, 64'd1);
        chk("t1_acready_back", {63'd0, acready}, 64'd1);
        chk("t1_busy", {63'd0, sts_busy}, 64'd0);
        pulse_clr();
        chk("clr_cnt", {32'd0, sts_match_cnt}, 64'd0);

        // ---------------- delay 20, back to back ----------------
        cfg_delay = 16'd20;
        for (int k = 0; k < 2; k++) begin
            do_snoop(44'h80 + 44'(k), AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
            chk("t2_lat", 64'(lat), 64'd21);
            chk("t2_resp", {59'd0, resp}, 64'h01);
            chk("t2_acready_low", {63'd0, ac_seen}, 64'd0);
        end
        chk("t2_cnt", {32'd0, sts_match_cnt}, 64'd2);

        // ---------------- address windows ----------------
        pulse_clr();
        cfg_delay       = 16'd3;
        cfg_crresp      = RESP_FWD;
        cfg_dflt_crresp = RESP_DFLT;
        cfg_addrflt_en  = 1'b1;
        cfg_win_en      = 4'b0010;
        cfg_win_base[0*ADDR_W +: ADDR_W] = 44'h0;
        cfg_win_size[0*SIZE_W +: SIZE_W] = 32'h1000;
        cfg_win_base[1*ADDR_W +: ADDR_W] = 44'h10;
        cfg_win_size[1*SIZE_W +: SIZE_W] = 32'h100;
        cfg_win_base[2*ADDR_W +: ADDR_W] = 44'h100;
        cfg_win_size[2*SIZE_W +: SIZE_W] = 32'h100;
        do_snoop(44'h0F, AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
        chk("w_0f_lat", 64'(lat), 64'd1);
        chk("w_0f_resp", {59'd0, resp}, 64'h10);
        do_snoop(44'h10, AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
        chk("w_10_lat", 64'(lat), 64'd4);
        chk("w_10_resp", {59'd0, resp}, 64'h0B);
        do_snoop(44'h10F, AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
        chk("w_10f_lat", 64'(lat), 64'd4);
        chk("w_10f_resp", {59'd0, resp}, 64'h0B);
        do_snoop(44'h110, AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
        chk("w_110_lat", 64'(lat), 64'd1);
        chk("w_110_resp", {59'd0, resp}, 64'h10);
        chk("w_cnt", {32'd0, sts_match_cnt}, 64'd2);

        // ---------------- ACSNOOP filter with window ----------------
        cfg_acflt_en = 1'b1;
        cfg_acsnoop  = 4'h1;
        do_snoop(44'h20, 4'h0, 1'b0, lat, resp, ac_seen);
        chk("ac0_lat", 64'(lat), 64'd1);
        chk("ac0_resp", {59'd0, resp}, 64'h10);
        do_snoop(44'h20, 4'h1, 1'b0, lat, resp, ac_seen);
        chk("ac1_lat", 64'(lat), 64'd4);
        chk("ac1_resp", {59'd0, resp}, 64'h0B);
        chk("ac_cnt", {32'd0, sts_match_cnt}, 64'd3);

        // zero-size window never hits; no enabled window matches nothing
        cfg_acflt_en = 1'b0;
        cfg_win_en   = 4'b0001;
        cfg_win_base[0*ADDR_W +: ADDR_W] = 44'h20;
        cfg_win_size[0*SIZE_W +: SIZE_W] = 32'h0;
        do_snoop(44'h20, AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
        chk("size0_resp", {59'd0, resp}, 64'h10);
        cfg_win_en = 4'b0000;
        do_snoop(44'h20, AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
        chk("nowin_resp", {59'd0, resp}, 64'h10);
        chk("nowin_cnt", {32'd0, sts_match_cnt}, 64'd3);

        // ---------------- one-shot ----------------
        cfg_addrflt_en = 1'b0;
        cfg_oneshot    = 1'b1;
        cfg_delay      = 16'd5;
        pulse_clr();
        chk("os_done0", {63'd0, sts_done}, 64'd0);
        do_snoop(44'h300, AC_CLEAN_INVALID, 1'b0, lat, resp, ac_seen);
        chk("os1_lat", 64'(lat), 64'd6);
        chk("os1_resp", {59'd0, resp}, 64'h0B);
        chk("os1_done", {63'd0, sts_done}, 64'd1);
        for (int k = 0; k < 2; k++) begin
            do_snoop(44'h300, AC_CLEAN_INVALID, 1'b0, lat, resp, ac_seen);
            chk("os_after_lat", 64'(lat), 64'd1);
            chk("os_after_resp", {59'd0, resp}, 64'h10);
        end
        chk("os_cnt", {32'd0, sts_match_cnt}, 64'd1);
        pulse_clr();
        chk("rearm_done", {63'd0, sts_done}, 64'd0);
        cfg_oneshot = 1'b0;
        do_snoop(44'h300, AC_MAKE_INVALID, 1'b0, lat, resp, ac_seen);
        chk("rearm_cnt", {32'd0, sts_match_cnt}, 64'd1);
        cfg_oneshot = 1'b1;
        do_snoop(44'h300, AC_MAKE_INVALID, 1'b1, lat, resp, ac_seen);
        chk("clrhit_resp", {59'd0, resp}, 64'h0B);
        chk("clrhit_done", {63'd0, sts_done}, 64'd1);
        chk("clrhit_cnt", {32'd0, sts_match_cnt}, 64'd1);
        cfg_oneshot = 1'b0;
        pulse_clr();

        // ---------------- cfg_en dropped mid-delay ----------------
        cfg_delay = 16'd100;
        acaddr    = 44'h500;
        acsnoop   = AC_READ_ONCE;
        acvalid   = 1'b1;
        @(negedge tb_clk);
        acvalid = 1'b0;
        repeat (29) @(negedge tb_clk);
        chk("en_busy", {63'd0, sts_busy}, 64'd1);
        chk("en_crvalid_pre", {63'd0, crvalid}, 64'd0);
        chk("en_acready_pre", {63'd0, acready}, 64'd0);
        cfg_en  = 1'b0;
        crready = 1'b0;
        @(negedge tb_clk);
        chk("en_crvalid", {63'd0, crvalid}, 64'd1);
        chk("en_resp", {59'd0, crresp}, 64'h10);
        cfg_en          = 1'b1;
        cfg_dflt_crresp = 5'h03;
        @(negedge tb_clk);
        chk("en_crvalid_hold", {63'd0, crvalid}, 64'd1);
        chk("en_resp_hold", {59'd0, crresp}, 64'h10);
        crready = 1'b1;
        @(negedge tb_clk);
        chk("en_crvalid_done", {63'd0, crvalid}, 64'd0);
        chk("en_cnt", {32'd0, sts_match_cnt}, 64'd0);
        chk("en_acready_back", {63'd0, acready}, 64'd1);
        cfg_dflt_crresp = RESP_DFLT;

        // ---------------- reset mid-delay ----------------
        cfg_delay = 16'd0;
        do_snoop(44'h600, AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
        chk("pre_rst_cnt", {32'd0, sts_match_cnt}, 64'd1);
        cfg_delay = 16'd100;
        acaddr    = 44'h700;
        acvalid   = 1'b1;
        @(negedge tb_clk);
        acvalid = 1'b0;
        repeat (9) @(negedge tb_clk);
        chk("mid_busy", {63'd0, sts_busy}, 64'd1);
        aresetn = 1'b0;
        #1;
        chk("arst_crvalid", {63'd0, crvalid}, 64'd0);
        chk("arst_busy", {63'd0, sts_busy}, 64'd0);
        chk("arst_acready", {63'd0, acready}, 64'd0);
        chk("arst_cnt", {32'd0, sts_match_cnt}, 64'd0);
        @(negedge tb_clk);
        aresetn = 1'b1;
        chk("arel_acready0", {63'd0, acready}, 64'd0);
        @(negedge tb_clk);
        chk("arel_acready1", {63'd0, acready}, 64'd1);
        cfg_delay = 16'd0;
        do_snoop(44'h800, AC_READ_ONCE, 1'b0, lat, resp, ac_seen);
        chk("post_rst_lat", 64'(lat), 64'd1);
        chk("post_rst_resp", {59'd0, resp}, 64'h0B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_devil_snoop_responder
